ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//   Consumer end of the ID/EX interface: takes decoded operands/controls from the ID/EX register,
//   performs ALU control decode, ALU op, write-register select and branch-target add, and registers
//   results into the EX/MEM stage. Sits between the ID/EX register and data memory. Owns an optional
//   iterative MULTU unit with HI/LO and drives ex_stall back to the front end.
// PARAMETERS
//   DW       32  datapath width (only 32 supported)
//   MUL_CYC  32  iteration count of the sequential multiplier (= DW)
// PORTS
//   clk            in   1   rising-edge clock; one clock domain
//   reset          in   1   synchronous, active-high
//   pc_incr        in   32  PC+4 from ID/EX
//   RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump  in 1 each  controls from ID/EX
//   ALUOp          in   2   00 add, 01 sub, 10 use Funct, 11 add
//   Funct          in   6   instr[5:0]
//   RD1,RD2        in   32  register-file operands
//   extend_immed   in   32  sign-extended immediate
//   rt,rd          in   5   destination candidates
//   ex_stall       out  1   combinational; 1 = front end must hold PC, IF/ID and ID/EX
//   branch_target_out out 32  registered pc_incr + (extend_immed<<2)
//   zero_out       out  1   registered (alu_result==0)
//   alu_result_out out  32  registered ALU/MFHI/MFLO result
//   wr_data_out    out  32  registered RD2 (store data)
//   wr_reg_out     out  5   registered RegDst ? rd : rt
//   MemtoReg_out,RegWrite_out,MemRead_out,MemWrite_out,Branch_out,Jump_out  out 1 each  registered
// BEHAVIOUR
//   - Reset: all outputs 0, HI=LO=0, state IDLE, ex_stall=0. Reset mid-multiply aborts, no HI/LO write.
//   - Latency 1: inputs in cycle T appear on *_out after edge ending T (no stall case).
//   - ALU B = ALUSrc ? extend_immed : RD2. ALUOp=10 Funct: 20 add, 22 sub, 24 and, 25 or,
//     2A slt (signed, result 0/1); any other Funct -> result 0. Add/sub wrap mod 2^32, no overflow trap.
//   - States IDLE -> BUSY -> DONE -> IDLE (multiply path only).
//     IDLE & is_multu (ALUOp=10, Funct=19): ex_stall=1, load multiplicand/multiplier, cnt=0 -> BUSY.
//     BUSY: one shift-add step/cycle, ex_stall=1, cnt++; cnt==MUL_CYC-1 -> DONE.
//     DONE: ex_stall=0, {HI,LO} <= 64-bit unsigned product, instruction retires normally -> IDLE;
//     multu still on inputs in DONE does NOT restart.
//   - Any cycle with ex_stall=1: EX/MEM loads a bubble (all control *_out =0, data *_out =0).
//   - MFHI (Funct=10)/MFLO (12): alu_result = HI/LO; a MFHI/MFLO in DONE cycle sees pre-update value
//     (impossible in practice: the multu itself occupies EX in DONE).
//   - Back-to-back multu: second starts from IDLE the cycle after DONE.
//   - branch_target and zero computed every cycle; Branch/Jump resolution is downstream.
// CONFIGURATION
//   EX_MULDIV_EN defined: MULTU/MFHI/MFLO, HI/LO regs, FSM and ex_stall as above.
//   Not defined: no HI/LO/FSM; Funct 19/10/12 fall to unknown-Funct (result 0, single cycle);
//   ex_stall tied 0.
// STRUCTURE
//   Package ex_pkg: ALUOp codes, Funct constants (ADD/SUB/AND/OR/SLT/MULTU/MFHI/MFLO),
//   ALU-operation enum, multiplier state enum {IDLE,BUSY,DONE}.
//   Sub-module ex_multu_seq (start, busy, done, a, b, {hi,lo}); instantiated only under EX_MULDIV_EN.
//   ALU control decode, ALU, EX/MEM register stay in this module.
// TESTING
//   1 reset with nonzero inputs -> all *_out 0, ex_stall 0 on first edge and while reset high.
//   2 ALUOp=10 Funct=22 RD1=5 RD2=5 RegDst=1 rd=9 RegWrite=1 -> next cycle alu_result 0, zero 1, wr_reg 9.
//   3 Funct=2A RD1=FFFFFFFF RD2=1 -> alu_result 1; ALUSrc=1 imm=FFFFFFFC pc_incr=100 -> target F0, result FFFFFFFB (add, ALUOp=00).
//   4 (EN) multu RD1=FFFFFFFF RD2=2 held -> ex_stall 1 for 33 cycles, bubbles out; then MFHI->1, MFLO->FFFFFFFE.
//   5 (EN) reset asserted at BUSY cnt=10 -> IDLE, ex_stall 0, MFHI/MFLO return 0.
//   6 (no EN) multu -> single cycle, alu_result 0, ex_stall never asserted.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared constants and types for the EX stage: ALUOp/Funct encodings, ALU operation and multiplier state enums.
package ex_pkg;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ADD2  = 2'b11;

    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_SLT,
        ALU_MFHI,
        ALU_MFLO,
        ALU_ZERO
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_e;

    // MULTU decodes to ALU_ZERO: its visible result lands in HI/LO, not on alu_result.
    function automatic alu_op_e decode_alu(input logic [1:0] alu_op_code,
                                           input logic [5:0] funct,
                                           input logic       muldiv_en);
        alu_op_e sel;
        sel = ALU_ZERO;
        case (alu_op_code)
            ALUOP_SUB: sel = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FUNCT_ADD:  sel = ALU_ADD;
                    FUNCT_SUB:  sel = ALU_SUB;
                    FUNCT_AND:  sel = ALU_AND;
                    FUNCT_OR:   sel = ALU_OR;
                    FUNCT_SLT:  sel = ALU_SLT;
                    FUNCT_MFHI: sel = muldiv_en ? ALU_MFHI : ALU_ZERO;
                    FUNCT_MFLO: sel = muldiv_en ? ALU_MFLO : ALU_ZERO;
                    default:    sel = ALU_ZERO;
                endcase
            end
            default: sel = ALU_ADD;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/ex_multu_seq.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, IDLE -> BUSY -> DONE -> IDLE.
module ex_multu_seq
    import ex_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MUL_CYC = DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    localparam int CW = (MUL_CYC > 1) ? $clog2(MUL_CYC) : 1;
    localparam logic [CW-1:0] LAST = CW'(MUL_CYC - 1);

    mul_state_e      state, state_next;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] mcand;
    logic [2*DW-1:0] acc;
    logic [DW-1:0]   mplier;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            mcand  <= '0;
            acc    <= '0;
            mplier <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand  <= {{DW{1'b0}}, a};
                        mplier <= b;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        acc <= acc + mcand;
                    end
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A start seen in IDLE stalls immediately so the operands are held for the load edge.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    busy       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                busy = 1'b1;
                if (cnt == LAST) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign {hi, lo} = acc;

endmodule

// File: rtl/ex_mem_stage.sv
// EX stage with EX/MEM pipeline register; define EX_MULDIV_EN to add MULTU/MFHI/MFLO with HI/LO and ex_stall.
module ex_mem_stage
    import ex_pkg::*;
#(
    parameter int DW      = 32,
    parameter int MUL_CYC = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [DW-1:0] pc_incr,
    input  logic          RegDst,
    input  logic          ALUSrc,
    input  logic          MemtoReg,
    input  logic          RegWrite,
    input  logic          MemRead,
    input  logic          MemWrite,
    input  logic          Branch,
    input  logic          Jump,
    input  logic [1:0]    ALUOp,
    input  logic [5:0]    Funct,
    input  logic [DW-1:0] RD1,
    input  logic [DW-1:0] RD2,
    input  logic [DW-1:0] extend_immed,
    input  logic [4:0]    rt,
    input  logic [4:0]    rd,
    output logic          ex_stall,
    output logic [DW-1:0] branch_target_out,
    output logic          zero_out,
    output logic [DW-1:0] alu_result_out,
    output logic [DW-1:0] wr_data_out,
    output logic [4:0]    wr_reg_out,
    output logic          MemtoReg_out,
    output logic          RegWrite_out,
    output logic          MemRead_out,
    output logic          MemWrite_out,
    output logic          Branch_out,
    output logic          Jump_out
);

    if (DW != 32 || MUL_CYC != DW) begin : g_bad_cfg
        $error("ex_mem_stage supports only DW=32 and MUL_CYC=DW");
    end

    logic [DW-1:0] hi_val, lo_val;
    logic [DW-1:0] alu_b, alu_result, branch_target;
    logic [4:0]    wr_reg;
    alu_op_e       alu_sel;

`ifdef EX_MULDIV_EN
    localparam logic MULDIV_EN = 1'b1;

    logic          is_multu, mul_busy, mul_done;
    logic [DW-1:0] mul_hi, mul_lo;
    logic [DW-1:0] hi_q, lo_q;

    assign is_multu = (ALUOp == ALUOP_FUNCT) && (Funct == FUNCT_MULTU);

    ex_multu_seq #(.DW(DW), .MUL_CYC(MUL_CYC)) u_multu (
        .clk   (clk),
        .reset (reset),
        .start (is_multu),
        .a     (RD1),
        .b     (RD2),
        .busy  (mul_busy),
        .done  (mul_done),
        .hi    (mul_hi),
        .lo    (mul_lo)
    );

    // HI/LO commit on the retiring DONE edge, so a read in that same cycle sees the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (mul_done) begin
            hi_q <= mul_hi;
            lo_q <= mul_lo;
        end
    end

    assign hi_val   = hi_q;
    assign lo_val   = lo_q;
    assign ex_stall = mul_busy & ~reset;
`else
    localparam logic MULDIV_EN = 1'b0;

    assign hi_val   = '0;
    assign lo_val   = '0;
    assign ex_stall = 1'b0;
`endif

    assign alu_sel       = decode_alu(ALUOp, Funct, MULDIV_EN);
    assign alu_b         = ALUSrc ? extend_immed : RD2;
    assign branch_target = pc_incr + (extend_immed << 2);
    assign wr_reg        = RegDst ? rd : rt;

    always_comb begin
        alu_result = '0;
        case (alu_sel)
            ALU_ADD:  alu_result = RD1 + alu_b;
            ALU_SUB:  alu_result = RD1 - alu_b;
            ALU_AND:  alu_result = RD1 & alu_b;
            ALU_OR:   alu_result = RD1 | alu_b;
            ALU_SLT:  alu_result = ($signed(RD1) < $signed(alu_b)) ? DW'(1) : '0;
            ALU_MFHI: alu_result = hi_val;
            ALU_MFLO: alu_result = lo_val;
            default:  alu_result = '0;
        endcase
    end

    // A stalled cycle pushes a full bubble so nothing downstream acts on a half-finished multiply.
    always_ff @(posedge clk) begin
        if (reset || ex_stall) begin
            branch_target_out <= '0;
            zero_out          <= 1'b0;
            alu_result_out    <= '0;
            wr_data_out       <= '0;
            wr_reg_out        <= '0;
            MemtoReg_out      <= 1'b0;
            RegWrite_out      <= 1'b0;
            MemRead_out       <= 1'b0;
            MemWrite_out      <= 1'b0;
            Branch_out        <= 1'b0;
            Jump_out          <= 1'b0;
        end else begin
            branch_target_out <= branch_target;
            zero_out          <= (alu_result == '0);
            alu_result_out    <= alu_result;
            wr_data_out       <= RD2;
            wr_reg_out        <= wr_reg;
            MemtoReg_out      <= MemtoReg;
            RegWrite_out      <= RegWrite;
            MemRead_out       <= MemRead;
            MemWrite_out      <= MemWrite;
            Branch_out        <= Branch;
            Jump_out          <= Jump;
        end
    end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage; multiply scenarios run only when EX_MULDIV_EN is defined.
module tb_ex_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_incr, RD1, RD2, extend_immed;
    logic        RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump;
    logic [1:0]  ALUOp;
    logic [5:0]  Funct;
    logic [4:0]  rt, rd;

    logic        ex_stall, zero_out;
    logic [31:0] branch_target_out, alu_result_out, wr_data_out;
    logic [4:0]  wr_reg_out;
    logic        MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, Jump_out;

    logic [107:0] out_vec;
    logic [107:0] exp_vec;
    logic [31:0]  model_hi, model_lo;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    ex_mem_stage dut (
        .clk(clk), .reset(reset), .pc_incr(pc_incr),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
        .ALUOp(ALUOp), .Funct(Funct), .RD1(RD1), .RD2(RD2), .extend_immed(extend_immed),
        .rt(rt), .rd(rd), .ex_stall(ex_stall),
        .branch_target_out(branch_target_out), .zero_out(zero_out),
        .alu_result_out(alu_result_out), .wr_data_out(wr_data_out), .wr_reg_out(wr_reg_out),
        .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
        .MemWrite_out(MemWrite_out), .Branch_out(Branch_out), .Jump_out(Jump_out)
    );

    assign out_vec = {branch_target_out, zero_out, alu_result_out, wr_data_out, wr_reg_out,
                      MemtoReg_out, RegWrite_out, MemRead_out, MemWrite_out, Branch_out, Jump_out};

    // Reference ALU straight from the instruction semantics.
    function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [5:0] f,
                                            input logic [31:0] a, input logic [31:0] b);
        if (op == 2'b01) return a - b;
        if (op != 2'b10) return a + b;
        case (f)
            6'h20: return a + b;
            6'h22: return a - b;
            6'h24: return a & b;
            6'h25: return a | b;
            6'h2A: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef EX_MULDIV_EN
            6'h10: return model_hi;
            6'h12: return model_lo;
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [107:0] expected_out();
        logic [31:0] b, res;
        b   = ALUSrc ? extend_immed : RD2;
        res = ref_alu(ALUOp, Funct, RD1, b);
        return {pc_incr + extend_immed * 32'd4, res == 32'd0, res, RD2, RegDst ? rd : rt,
                MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        {pc_incr, RD1, RD2, extend_immed} = '0;
        {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump} = '0;
        ALUOp = 2'b00; Funct = 6'h00; rt = 5'd0; rd = 5'd0;
    endtask

    task automatic applyStimulus();
        logic [5:0] funct_set [8];
        funct_set = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h10, 6'h12, 6'h00};
        pc_incr = $urandom; RD1 = $urandom; RD2 = $urandom; extend_immed = $urandom;
        {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump} = 8'($urandom);
        ALUOp = 2'($urandom); rt = 5'($urandom); rd = 5'($urandom);
        Funct = funct_set[$urandom_range(0, 7)];
        if ($urandom_range(0, 3) == 0) Funct = 6'($urandom);
`ifdef EX_MULDIV_EN
        if (Funct == 6'h19) Funct = 6'h24;
`endif
        if ($urandom_range(0, 5) == 0) RD2 = RD1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        applyStimulus();
        ALUOp = 2'b10; Funct = 6'h19; RegWrite = 1'b1; RD1 = 32'h1234; RD2 = 32'h5678;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_vec !== '0 || ex_stall !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_state: got out=%h stall=%b expected out=0 stall=0", out_vec, ex_stall);
            end
        end
        clear_inputs();
        tick();
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
    endtask

    task automatic test_sub_zero();
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h22; RD1 = 32'd5; RD2 = 32'd5;
        RegDst = 1'b1; rd = 5'd9; rt = 5'd3; RegWrite = 1'b1;
        tick();
        checks++;
        if (alu_result_out !== 32'd0) begin
            errors++; $display("[TB] FAIL sub_result: got %h expected 00000000", alu_result_out);
        end
        checks++;
        if (zero_out !== 1'b1) begin
            errors++; $display("[TB] FAIL sub_zero: got %b expected 1", zero_out);
        end
        checks++;
        if (wr_reg_out !== 5'd9 || RegWrite_out !== 1'b1) begin
            errors++; $display("[TB] FAIL sub_wr_reg: got %0d/%b expected 9/1", wr_reg_out, RegWrite_out);
        end
    endtask

    task automatic test_slt_branch();
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h2A; RD1 = 32'hFFFF_FFFF; RD2 = 32'd1;
        tick();
        checks++;
        if (alu_result_out !== 32'd1) begin
            errors++; $display("[TB] FAIL slt_signed: got %h expected 00000001", alu_result_out);
        end
        ALUOp = 2'b00; Funct = 6'h00; ALUSrc = 1'b1;
        extend_immed = 32'hFFFF_FFFC; pc_incr = 32'h100;
        tick();
        checks++;
        if (branch_target_out !== 32'hF0) begin
            errors++; $display("[TB] FAIL branch_target: got %h expected 000000f0", branch_target_out);
        end
        checks++;
        if (alu_result_out !== 32'hFFFF_FFFB) begin
            errors++; $display("[TB] FAIL imm_add: got %h expected fffffffb", alu_result_out);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            applyStimulus();
            #1;
            checks++;
            if (ex_stall !== 1'b0) begin
                errors++; $display("[TB] FAIL random_stall[%0d]: got %b expected 0", i, ex_stall);
            end
            exp_vec = expected_out();
            tick();
            checks++;
            if (out_vec !== exp_vec) begin
                errors++;
                $display("[TB] FAIL random_out[%0d] op=%b f=%h: got %h expected %h", i, ALUOp, Funct, out_vec, exp_vec);
            end
        end
    endtask

`ifdef EX_MULDIV_EN
    // Holds a multu until the stall drops, checking bubbles; leaves the bench in the DONE cycle.
    task automatic run_multu(input string tag);
        int n;
        n = 0;
        #1;
        while (ex_stall === 1'b1 && n < 100) begin
            tick();
            n++;
            checks++;
            if (out_vec !== '0) begin
                errors++; $display("[TB] FAIL %s_bubble[%0d]: got %h expected 0", tag, n, out_vec);
            end
        end
        checks++;
        if (n != 33) begin
            errors++; $display("[TB] FAIL %s_stall_len: got %0d expected 33", tag, n);
        end
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h10;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL %s_mfhi_stall: got %b expected 0", tag, ex_stall);
        end
        tick();
        checks++;
        if (alu_result_out !== exp_hi) begin
            errors++; $display("[TB] FAIL %s_mfhi: got %h expected %h", tag, alu_result_out, exp_hi);
        end
        Funct = 6'h12;
        tick();
        checks++;
        if (alu_result_out !== exp_lo) begin
            errors++; $display("[TB] FAIL %s_mflo: got %h expected %h", tag, alu_result_out, exp_lo);
        end
    endtask

    task automatic test_multu();
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h19; RD1 = 32'hFFFF_FFFF; RD2 = 32'd2;
        RegDst = 1'b1; rd = 5'd4; RegWrite = 1'b1;
        run_multu("multu");
        exp_vec = expected_out();
        tick();
        checks++;
        if (out_vec !== exp_vec) begin
            errors++; $display("[TB] FAIL multu_retire: got %h expected %h", out_vec, exp_vec);
        end
        {model_hi, model_lo} = 64'(RD1) * 64'(RD2);
        read_hilo("multu", 32'd1, 32'hFFFF_FFFE);
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h19;
        for (int rep = 0; rep < 2; rep++) begin
            RD1 = $urandom; RD2 = $urandom;
            run_multu("b2b");
            tick();
            {model_hi, model_lo} = 64'(RD1) * 64'(RD2);
        end
        read_hilo("b2b", model_hi, model_lo);
    endtask

    task automatic test_reset_mid_multu();
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h19; RD1 = 32'hDEAD_BEEF; RD2 = 32'h1234_5677;
        #1;
        for (int i = 0; i < 11; i++) tick();
        reset = 1'b1;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL midreset_stall: got %b expected 0", ex_stall);
        end
        tick();
        checks++;
        if (out_vec !== '0) begin
            errors++; $display("[TB] FAIL midreset_out: got %h expected 0", out_vec);
        end
        clear_inputs();
        reset = 1'b0;
        model_hi = '0; model_lo = '0;
        read_hilo("midreset", 32'd0, 32'd0);
    endtask
`else
    task automatic test_multu_disabled();
        clear_inputs();
        ALUOp = 2'b10; Funct = 6'h19; RD1 = 32'hFFFF_FFFF; RD2 = 32'd2; RegWrite = 1'b1;
        #1;
        checks++;
        if (ex_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL nomul_stall: got %b expected 0", ex_stall);
        end
        exp_vec = expected_out();
        tick();
        checks++;
        if (out_vec !== exp_vec || alu_result_out !== 32'd0) begin
            errors++; $display("[TB] FAIL nomul_result: got %h expected %h", out_vec, exp_vec);
        end
        Funct = 6'h10;
        tick();
        checks++;
        if (alu_result_out !== 32'd0 || ex_stall !== 1'b0) begin
            errors++; $display("[TB] FAIL nomul_mfhi: got %h/%b expected 0/0", alu_result_out, ex_stall);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        #2;
        test_reset();
        test_sub_zero();
        test_slt_branch();
        test_random();
`ifdef EX_MULDIV_EN
        test_multu();
        test_back_to_back();
        test_reset_mid_multu();
        test_random();
`else
        test_multu_disabled();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
